// File: rtl/pe_bcast_pkg.sv
// Shared types and constants for the PE activation broadcaster.
package pe_bcast_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE_PKT,
    ST_WAIT_COMP
  } state_e;

  localparam int unsigned BUF_DEPTH = 2;

  // Completion packets go to the root controller: MSB set, every other address bit clear.
  function automatic logic [63:0] done_addr(input int unsigned addr_w);
    done_addr = 64'd1 << (addr_w - 1);
  endfunction

endpackage

// File: rtl/pe_act_broadcaster_if.sv
// Control, register-file read and router injection signals of the activation broadcaster.
interface pe_act_broadcaster_if #(
  parameter int DATA_W   = 16,
  parameter int ACT_NO_W = 6,
  parameter int ADDR_W   = 12
);
  logic                start;
  logic [ACT_NO_W-1:0] in_act_no;
  logic                rd_en;
  logic [ACT_NO_W-1:0] rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                send_valid;
  logic                send_ready;
  logic [DATA_W-1:0]   send_data;
  logic [ADDR_W-1:0]   send_addr;
  logic                comp_done;
  logic                busy;
  logic [ACT_NO_W-1:0] sent_cnt;

  modport master (
    input  start, in_act_no, rd_data, send_ready, comp_done,
    output rd_en, rd_addr, send_valid, send_data, send_addr, busy, sent_cnt
  );

  modport slave (
    output start, in_act_no, rd_data, send_ready, comp_done,
    input  rd_en, rd_addr, send_valid, send_data, send_addr, busy, sent_cnt
  );
endinterface

// File: rtl/pe_bcast_fifo.sv
// Two-entry output buffer; a push and a pop in the same cycle on a full buffer keep it full.
module pe_bcast_fifo
  import pe_bcast_pkg::*;
#(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] mem_d [BUF_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + 2'(do_push) - 2'(do_pop);
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;

endmodule

// File: rtl/pe_act_broadcaster.sv
// Streams a PE's activations from its register file into the router, then sends a
// completion packet to the root controller and waits for the computation-done indication.
module pe_act_broadcaster
  import pe_bcast_pkg::*;
#(
  parameter int PE_IDX    = 0,
  parameter int DATA_W    = 16,
  parameter int ACT_NO_W  = 6,
  parameter int ADDR_W    = 12,
  parameter int IDX_SHIFT = 6,
  parameter int SKIP_ZERO = 0
) (
  input logic               clk,
  input logic               rst,
  pe_act_broadcaster_if.master bus
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } pkt_t;

  localparam logic [ADDR_W-1:0] DONE_ADDR = ADDR_W'(done_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] PE_ADDR   = ADDR_W'(PE_IDX);
  localparam logic [DATA_W-1:0] PE_DATA   = DATA_W'(PE_IDX);

  state_e              state_q, state_d;
  logic [ACT_NO_W-1:0] n_q, n_d;
  logic [ACT_NO_W-1:0] idx_q, idx_d;
  logic [ACT_NO_W-1:0] sent_cnt_q, sent_cnt_d;
  logic                inflight_q, inflight_d;
  logic [ACT_NO_W-1:0] rd_idx_q, rd_idx_d;

  pkt_t       cap_pkt, head_pkt;
  logic       fifo_full, fifo_empty;
  logic [1:0] fifo_count;
  logic       cap_keep, push, pop, credit, rd_fire;
  logic [2:0] occ_after_pop;

  pe_bcast_fifo #(.W(DATA_W + ADDR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (cap_pkt),
    .rd_data (head_pkt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Read credit counts reads still in flight so the buffer can never overflow on return.
  always_comb begin
    cap_pkt.data  = bus.rd_data;
    cap_pkt.addr  = PE_ADDR + (ADDR_W'(rd_idx_q) << IDX_SHIFT);
    cap_keep      = !((SKIP_ZERO != 0) && (bus.rd_data == '0));
    pop           = !fifo_empty && bus.send_ready;
    push          = inflight_q && cap_keep && (!fifo_full || pop);
    occ_after_pop = 3'(fifo_count) - 3'(pop);
    credit        = (occ_after_pop + 3'(inflight_q)) < 3'd2;
    rd_fire       = (state_q == ST_ISSUE) && (idx_q != n_q) && credit;
    inflight_d    = rd_fire;
    rd_idx_d      = rd_fire ? idx_q : rd_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      sent_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      sent_cnt_q <= sent_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_q <= rd_idx_d;
  end

  // Next state: DRAIN leaves once the buffer will be empty after this cycle's pop.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    sent_cnt_d = sent_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_ISSUE;
          n_d        = bus.in_act_no;
          idx_d      = '0;
          sent_cnt_d = '0;
        end
      end
      ST_ISSUE: begin
        if (idx_q == n_q)  state_d = ST_DRAIN;
        else if (rd_fire)  idx_d   = idx_q + ACT_NO_W'(1);
      end
      ST_DRAIN: begin
        if (!inflight_q && (fifo_count == 2'(pop))) state_d = ST_DONE_PKT;
      end
      ST_DONE_PKT: begin
        if (bus.send_ready) state_d = ST_WAIT_COMP;
      end
      ST_WAIT_COMP: begin
        if (bus.comp_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop && (sent_cnt_q < n_q)) sent_cnt_d = sent_cnt_q + ACT_NO_W'(1);
  end

  always_comb begin
    bus.rd_en      = rd_fire;
    bus.rd_addr    = rd_fire ? idx_q : '0;
    bus.busy       = (state_q != ST_IDLE);
    bus.sent_cnt   = sent_cnt_q;
    bus.send_valid = 1'b0;
    bus.send_data  = '0;
    bus.send_addr  = '0;
    if (state_q == ST_DONE_PKT) begin
      bus.send_valid = 1'b1;
      bus.send_data  = PE_DATA;
      bus.send_addr  = DONE_ADDR;
    end else if (!fifo_empty) begin
      bus.send_valid = 1'b1;
      bus.send_data  = head_pkt.data;
      bus.send_addr  = head_pkt.addr;
    end
  end

endmodule

// File: tb/tb_pe_act_broadcaster.sv
// Bench for pe_act_broadcaster: a dense (PE 3) and a sparse (PE 5) instance, a queue-based
// scoreboard fed from a packet-level model and a monitor that checks every router transfer.
module tb_pe_act_broadcaster;
  localparam int DATA_W = 16, ACT_NO_W = 6, ADDR_W = 12, IDX_SHIFT = 6;
  localparam int PE0 = 3, PE1 = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_act_broadcaster_if #(.DATA_W(DATA_W), .ACT_NO_W(ACT_NO_W), .ADDR_W(ADDR_W)) bus0 ();
  pe_act_broadcaster_if #(.DATA_W(DATA_W), .ACT_NO_W(ACT_NO_W), .ADDR_W(ADDR_W)) bus1 ();

  pe_act_broadcaster #(.PE_IDX(PE0), .DATA_W(DATA_W), .ACT_NO_W(ACT_NO_W), .ADDR_W(ADDR_W),
                       .IDX_SHIFT(IDX_SHIFT), .SKIP_ZERO(0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pe_act_broadcaster #(.PE_IDX(PE1), .DATA_W(DATA_W), .ACT_NO_W(ACT_NO_W), .ADDR_W(ADDR_W),
                       .IDX_SHIFT(IDX_SHIFT), .SKIP_ZERO(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic                sel = 1'b0, start = 1'b0, send_ready = 1'b1, comp_done = 1'b0;
  logic [ACT_NO_W-1:0] in_act_no = '0;
  logic [DATA_W-1:0]   mem [64];
  int                  rmode = 0;

  assign bus0.start      = start & ~sel;
  assign bus1.start      = start & sel;
  assign bus0.in_act_no  = in_act_no;
  assign bus1.in_act_no  = in_act_no;
  assign bus0.send_ready = send_ready;
  assign bus1.send_ready = send_ready;
  assign bus0.comp_done  = comp_done & ~sel;
  assign bus1.comp_done  = comp_done & sel;

  // Activation register file: data appears one cycle after the address.
  always @(posedge clk) begin
    bus0.rd_data <= mem[bus0.rd_addr];
    bus1.rd_data <= mem[bus1.rd_addr];
  end

  logic [3:0] pat = 4'b1001;
  int         ph  = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: send_ready = 1'b1;
      1: begin send_ready = pat[ph]; ph = (ph + 1) % 4; end
      default: send_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic                m_valid, m_ready, m_rd_en, m_busy, m_start, m_comp;
  logic [DATA_W-1:0]   m_data;
  logic [ADDR_W-1:0]   m_addr;
  logic [ACT_NO_W-1:0] m_rd_addr, m_sent;
  assign m_valid   = sel ? bus1.send_valid : bus0.send_valid;
  assign m_ready   = send_ready;
  assign m_rd_en   = sel ? bus1.rd_en      : bus0.rd_en;
  assign m_rd_addr = sel ? bus1.rd_addr    : bus0.rd_addr;
  assign m_busy    = sel ? bus1.busy       : bus0.busy;
  assign m_data    = sel ? bus1.send_data  : bus0.send_data;
  assign m_addr    = sel ? bus1.send_addr  : bus0.send_addr;
  assign m_sent    = sel ? bus1.sent_cnt   : bus0.sent_cnt;
  assign m_start   = sel ? bus1.start      : bus0.start;
  assign m_comp    = sel ? bus1.comp_done  : bus0.comp_done;

  // Scoreboard entries: {is_completion, data, addr}.
  logic [28:0] exp_q[$];
  int exp_first = -1, exp_done = -1, exp_sent = 0, exp_reads = 0;
  bit chk_outstanding = 1'b0;
  int timeout_req = 0;

  int vectors = 0, miscompares = 0;
  int timeout_seen = 0, cyc = 0, reads = 0, issued = 0, accepted = 0;
  bit running = 0, first_seen = 0, in_wait = 0, pend_idle = 0, pend_busy = 0, prev_stall = 0;
  logic [27:0] prev_pay = '0;
  logic [28:0] mon_e;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (timeout_req != timeout_seen) begin
      timeout_seen = timeout_req;
      vectors++;
      miscompares++;
      $display("FAIL wait_bound: DUT did not reach the expected point within its cycle budget (t=%0t)", $time);
    end
    if (rst) begin
      check("reset_outputs", 64'({m_rd_en, m_rd_addr, m_valid, m_data, m_addr, m_busy, m_sent}), 64'd0);
      running = 0; in_wait = 0; pend_idle = 0; pend_busy = 0; prev_stall = 0;
    end else begin
      if (pend_idle) begin check("idle_after_comp_done", 64'(m_busy), 64'd0); pend_idle = 0; end
      if (pend_busy) begin check("early_comp_done_ignored", 64'(m_busy), 64'd1); pend_busy = 0; end
      if (prev_stall) check("stall_hold", 64'({m_valid, m_data, m_addr}), 64'({1'b1, prev_pay}));
      if (running) begin
        cyc++;
        if (m_rd_en) begin reads++; issued++; end
        if (m_valid && !first_seen) begin
          first_seen = 1;
          if (exp_first >= 0) check("first_valid_cycle", 64'(cyc), 64'(exp_first));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_packet: got data %0h addr %0h, none required", m_data, m_addr);
          end else begin
            mon_e = exp_q.pop_front();
            check("packet", 64'({m_data, m_addr}), 64'(mon_e[27:0]));
            if (mon_e[28]) begin
              if (exp_done >= 0) check("done_cycle", 64'(cyc), 64'(exp_done));
              check("sent_cnt", 64'(m_sent), 64'(exp_sent));
              check("read_count", 64'(reads), 64'(exp_reads));
              in_wait = 1;
            end else begin
              accepted++;
            end
          end
        end
        if (chk_outstanding) check("outstanding_le_2", 64'((issued - accepted) <= 2), 64'd1);
        if (m_comp) begin
          if (in_wait) begin pend_idle = 1; running = 0; in_wait = 0; end
          else pend_busy = 1;
        end
      end
      if (m_start && !m_busy && !running) begin
        running = 1; cyc = 0; reads = 0; issued = 0; accepted = 0; first_seen = 0; in_wait = 0;
      end
      prev_stall = m_valid && !m_ready;
      prev_pay   = {m_data, m_addr};
    end
  end

  task automatic arm(input bit s, input int n, input int first, input int done);
    int pe, kept;
    sel = s;
    pe = s ? PE1 : PE0;
    kept = 0;
    for (int i = 0; i < n; i++) begin
      if (!(s && mem[i] == '0)) begin
        exp_q.push_back({1'b0, mem[i], 12'(pe + i * (1 << IDX_SHIFT))});
        kept++;
      end
    end
    exp_q.push_back({1'b1, 16'(pe), 12'h800});
    exp_sent = kept; exp_reads = n; exp_first = first; exp_done = done;
    chk_outstanding = !s;
    @(posedge clk); #1;
    start = 1'b1;
    in_act_no = 6'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!in_wait && k < budget) begin @(posedge clk); #1; k++; end
    if (!in_wait) begin
      timeout_req++;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      comp_done = 1'b1;
      @(posedge clk); #1;
      comp_done = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 16'hFFFF));
  endtask

  initial begin
    int k;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    mem[0] = 16'd5; mem[1] = 16'd6; mem[2] = 16'd7; mem[3] = 16'd8;
    arm(0, 4, 3, 7);
    wait_done(60);

    arm(0, 0, 3, 3);
    wait_done(40);

    rmode = 1;
    fill(6);
    arm(0, 6, -1, -1);
    wait_done(200);
    rmode = 0;

    mem[0] = 16'd0; mem[1] = 16'd9; mem[2] = 16'd0; mem[3] = 16'd4;
    arm(1, 4, -1, -1);
    wait_done(60);

    // start while streaming and an early comp_done must both be ignored
    fill(5);
    arm(0, 5, 3, 8);
    start = 1'b1; in_act_no = 6'd2;
    @(posedge clk); #1;
    start = 1'b0; in_act_no = 6'd5; comp_done = 1'b1;
    @(posedge clk); #1;
    comp_done = 1'b0;
    wait_done(60);

    // reset while index 2 is being read, then replay from index 0
    fill(5);
    arm(0, 5, -1, -1);
    k = 0;
    while (!(m_rd_en && m_rd_addr == 6'd2) && k < 20) begin @(posedge clk); #1; k++; end
    if (k >= 20) timeout_req++;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    arm(0, 5, 3, 8);
    wait_done(60);

    rmode = 2;
    for (int r = 0; r < 8; r++) begin
      fill(16);
      arm(1'(r % 2), $urandom_range(0, 12), -1, -1);
      wait_done(400);
    end
    rmode = 0;

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
